// File: rtl/sony_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sony_sync_pkg
// Description : Shared code words, FSM state type and pixel clamp helpers for
//               the Sony block-camera sync encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package sony_sync_pkg;

    localparam logic [15:0] CODE_FF    = 16'hFFFF;
    localparam logic [15:0] CODE_00    = 16'h0000;
    localparam logic [15:0] SAV_ACT    = 16'h8080;
    localparam logic [15:0] EAV_ACT    = 16'h9D9D;
    localparam logic [15:0] SAV_VBL    = 16'hABAB;
    localparam logic [15:0] EAV_VBL    = 16'hB6B6;
    localparam logic [15:0] BLANK_WORD = 16'h8010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAV    = 3'd1,
        ACTIVE = 3'd2,
        EAV    = 3'd3,
        HBLANK = 3'd4
    } state_t;

    // Keep the reserved values 00/FF out of active data so that a receiver
    // can never mistake pixels for the start of a preamble.
    function automatic logic [7:0] clamp_byte(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b == 8'h00) r = 8'h01;
        if (b == 8'hFF) r = 8'hFE;
        return r;
    endfunction

    function automatic logic [15:0] clamp_word(input logic [15:0] w);
        return {clamp_byte(w[15:8]), clamp_byte(w[7:0])};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sony_sync_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : sony_sync_raster_counter
// Description : Word-within-segment and line-within-frame counters with the
//               active-line and last-line flags used by the encoder FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module sony_sync_raster_counter #(
    parameter int V_ACTIVE = 1080,
    parameter int V_BLANK  = 45
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        word_clear,
    input  logic        line_clear,
    input  logic        line_advance,
    output logic [11:0] word_cnt,
    output logic [10:0] line_cnt,
    output logic        is_active_line,
    output logic        is_last_line
);

    localparam logic [10:0] c_LINE_LAST  = 11'(V_ACTIVE + V_BLANK - 1);
    localparam logic [10:0] c_ACT_LINES  = 11'(V_ACTIVE);

    logic [11:0] r_word_cnt;
    logic [10:0] r_line_cnt;

    // Word counter restarts at every segment boundary, otherwise free-runs.
    always_ff @(posedge clock_in) begin
        if (reset || word_clear) begin
            r_word_cnt <= 12'd0;
        end else begin
            r_word_cnt <= r_word_cnt + 12'd1;
        end
    end

    // Line counter steps at the end of each line and wraps after the last one.
    always_ff @(posedge clock_in) begin
        if (reset || line_clear) begin
            r_line_cnt <= 11'd0;
        end else if (line_advance) begin
            r_line_cnt <= (r_line_cnt == c_LINE_LAST) ? 11'd0 : r_line_cnt + 11'd1;
        end
    end

    assign word_cnt       = r_word_cnt;
    assign line_cnt       = r_line_cnt;
    assign is_active_line = (r_line_cnt < c_ACT_LINES);
    assign is_last_line   = (r_line_cnt == c_LINE_LAST);

endmodule
`default_nettype wire

// File: rtl/sony_block_sync_encoder.sv
`default_nettype none
// ============================================================================
// Module      : sony_block_sync_encoder
// Description : Generates the 16-bit Sony block-camera stream with embedded
//               SAV/EAV sync codes, pulling YUV422 words from upstream.
// Revision    : 1.0 - initial release
// ============================================================================
module sony_block_sync_encoder
    import sony_sync_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_BLANK  = 272,
    parameter int V_ACTIVE = 1080,
    parameter int V_BLANK  = 45
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] data_out,
    output logic        frame_start,
    output logic        line_start,
    output logic        busy,
    output logic        underflow
);

    localparam logic [11:0] c_ACT_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] c_BLK_LAST = 12'(H_BLANK - 1);
    localparam logic [11:0] c_CODE_END = 12'd3;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_word_clear;
    logic        w_line_clear;
    logic        w_line_advance;
    logic [11:0] w_word_cnt;
    logic [10:0] w_line_cnt;
    logic        w_is_active_line;
    logic        w_is_last_line;
    logic [15:0] w_data_next;
    logic        w_line_start_next;
    logic        w_frame_start_next;
    logic        w_underflow_set;

    logic [15:0] r_data_out;
    logic        r_frame_start;
    logic        r_line_start;
    logic        r_busy;
    logic        r_underflow;

    sony_sync_raster_counter #(
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK)
    ) u_raster (
        .clock_in       (clock_in),
        .reset          (reset),
        .word_clear     (w_word_clear),
        .line_clear     (w_line_clear),
        .line_advance   (w_line_advance),
        .word_cnt       (w_word_cnt),
        .line_cnt       (w_line_cnt),
        .is_active_line (w_is_active_line),
        .is_last_line   (w_is_last_line)
    );

    // State register.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Segment sequencing; enable only matters when a frame is about to start.
    always_comb begin
        w_state_next   = r_state;
        w_word_clear   = 1'b0;
        w_line_clear   = 1'b0;
        w_line_advance = 1'b0;
        case (r_state)
            IDLE: begin
                w_word_clear = 1'b1;
                if (enable) begin
                    w_state_next = SAV;
                    w_line_clear = 1'b1;
                end
            end
            SAV: begin
                if (w_word_cnt == c_CODE_END) begin
                    w_state_next = ACTIVE;
                    w_word_clear = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_word_cnt == c_ACT_LAST) begin
                    w_state_next = EAV;
                    w_word_clear = 1'b1;
                end
            end
            EAV: begin
                if (w_word_cnt == c_CODE_END) begin
                    w_state_next = HBLANK;
                    w_word_clear = 1'b1;
                end
            end
            HBLANK: begin
                if (w_word_cnt == c_BLK_LAST) begin
                    w_word_clear   = 1'b1;
                    w_line_advance = 1'b1;
                    w_state_next   = (w_is_last_line && !enable) ? IDLE : SAV;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_word_clear = 1'b1;
            end
        endcase
    end

    assign pix_ready = (r_state == ACTIVE) && w_is_active_line;

    // Output word selection for the slot the FSM currently occupies.
    always_comb begin
        w_data_next        = BLANK_WORD;
        w_line_start_next  = 1'b0;
        w_frame_start_next = 1'b0;
        w_underflow_set    = 1'b0;
        case (r_state)
            SAV, EAV: begin
                case (w_word_cnt[1:0])
                    2'd0:    w_data_next = CODE_FF;
                    2'd3: begin
                        if (r_state == SAV) w_data_next = w_is_active_line ? SAV_ACT : SAV_VBL;
                        else                w_data_next = w_is_active_line ? EAV_ACT : EAV_VBL;
                    end
                    default: w_data_next = CODE_00;
                endcase
                if (r_state == SAV && w_word_cnt == 12'd0) begin
                    w_line_start_next  = 1'b1;
                    w_frame_start_next = (w_line_cnt == 11'd0);
                end
            end
            ACTIVE: begin
                if (w_is_active_line) begin
                    if (pix_valid) w_data_next = clamp_word(pix_data);
                    else           w_underflow_set = 1'b1;
                end
            end
            default: w_data_next = BLANK_WORD;
        endcase
    end

    // Registered stream outputs; markers travel with the word they tag.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_data_out    <= BLANK_WORD;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_data_out    <= w_data_next;
            r_frame_start <= w_frame_start_next;
            r_line_start  <= w_line_start_next;
            r_busy        <= (r_state != IDLE);
            r_underflow   <= r_underflow | w_underflow_set;
        end
    end

    assign data_out    = r_data_out;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign busy        = r_busy;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: doc/sony_block_sync_encoder.md
Name: sony_block_sync_encoder

Overview:
- Generates the 16-bit parallel Sony block-camera stream with embedded sync codes from a pixel source; this is the transmit side of the camera-stream decoder.
- The block owns raster timing and pulls YUV422 word pairs (C on [15:8], Y on [7:0]) from upstream via valid/ready.
- It inserts SAV/EAV preambles (FFFF, 0000, 0000, XYXY) and blanking words.
- Used as a loopback/test source for the camera-to-CSI-2 bridge and to emulate the camera in simulation.

Parameters:
- H_ACTIVE, 1920, active words per line.
- H_BLANK, 272, blanking words per line, excluding the 8 code words; must be >= 1.
- V_ACTIVE, 1080, active lines per frame.
- V_BLANK, 45, vertical-blanking lines per frame; must be >= 2.

Ports:
- clock_in  in  1  word clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled only at frame boundaries.
- pix_data  in  16  upstream pixel word: [15:8] = C, [7:0] = Y.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  block consumes pix_data this cycle.
- data_out  out  16  encoded stream word, registered.
- frame_start  out  1  one-cycle pulse on the cycle data_out carries the first FFFF of line 0.
- line_start  out  1  one-cycle pulse on the cycle data_out carries the first FFFF of any line.
- busy  out  1  high while a frame is in progress.
- underflow  out  1  sticky; set when an active word is needed and pix_valid=0; cleared only by reset.

Behaviour:
- Reset values:
  - data_out = 16'h8010 (blanking word).
  - pix_ready, frame_start, line_start, busy and underflow = 0.
  - state = IDLE; all counters = 0.
- Line layout, in order:
  - SAV: 4 words.
  - ACTIVE: H_ACTIVE words.
  - EAV: 4 words.
  - HBLANK: H_BLANK words of 8010.
  - Line period = H_ACTIVE + H_BLANK + 8 cycles.
- Frame layout: V_ACTIVE active lines, then V_BLANK blanking lines. Line counter wraps at V_ACTIVE + V_BLANK - 1.
- Code word XYXY:
  - Active lines: SAV = 8080, EAV = 9D9D.
  - Blanking lines: SAV = ABAB, EAV = B6B6.
  - Code sequence per preamble: FFFF, 0000, 0000, XYXY (2-bit index).
- States: IDLE, SAV, ACTIVE, EAV, HBLANK.
  - IDLE -> SAV when enable=1. Line counter = 0, frame_start fires.
  - SAV -> ACTIVE after index 3.
  - ACTIVE -> EAV after word H_ACTIVE-1 (12-bit word counter).
  - EAV -> HBLANK after index 3.
  - HBLANK -> SAV after word H_BLANK-1 if the line is not last.
  - On the last line of a frame, HBLANK -> SAV if enable=1, else -> IDLE.
- Blanking lines run ACTIVE with 8010 words and pix_ready = 0.
- IDLE outputs 8010 continuously; busy = 0 only in IDLE.
- pix_ready = 1 combinationally in ACTIVE on active lines only, regardless of pix_valid.
- Latency: a word accepted on cycle N (pix_ready & pix_valid) appears on data_out at N+1.
- Underflow: if pix_ready=1 and pix_valid=0, output 8010 for that slot and set underflow. Raster timing never stalls.
- Clamp: each byte of pix_data is clamped independently:
  - 8'h00 -> 8'h01.
  - 8'hFF -> 8'hFE.
  - Reserved codes never appear in active data.
- frame_start and line_start are aligned with data_out (registered together), not with the state.
- enable deasserted mid-frame: the current frame completes, including all V_BLANK lines, then IDLE.
- Reset mid-line: the next cycle is IDLE with data_out = 8010; no partial code is completed.
- Counter widths: word 12 bits; line 11 bits.

Decomposition:
- Package sony_sync_pkg holds:
  - Constants CODE_FF = 16'hFFFF, CODE_00 = 16'h0000, SAV_ACT = 16'h8080, EAV_ACT = 16'h9D9D, SAV_VBL = 16'hABAB, EAV_VBL = 16'hB6B6, BLANK_WORD = 16'h8010.
  - The state enum.
- One sub-module, sony_sync_raster_counter, produces word/line counters, the is_active_line flag and the last-line flag; the top holds the FSM, output mux and clamp.

Test Plan:
- H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, V_BLANK=2, enable=1, pix_data incrementing from 16'h1020 with valid always 1 -> data_out repeats every 20 cycles:
  - Line 0: FFFF,0000,0000,8080, 1020..1027, FFFF,0000,0000,9D9D, 8010 x4.
  - Lines 2-3: ABAB/B6B6 with 8010 in the active slots.
  - frame_start every 80 cycles; underflow stays 0.
- pix_data = 16'hFF00 on an active slot -> data_out = 16'hFE01.
- pix_valid=0 for one active slot -> that word = 8010, following words continue in sequence, underflow = 1 until reset.
- enable dropped during line 1 -> lines 2-3 still emitted, then data_out = 8010 constantly, busy = 0, no new FFFF.
- reset asserted on the third SAV word -> next cycle data_out = 8010, busy = 0. After release with enable=1, first output sequence is FFFF,0000,0000,8080 with frame_start=1 on the FFFF.
- Loopback into the camera decoder with full parameters -> 1080 line-valid bursts of 1920 words per frame, frame-valid toggling once per frame.
